// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline package: stage FSM state type, occupancy width,
// and a helper that maps a state to its entry count.
package pipe_stage_reg_pkg;

   localparam int OCC_W = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } state_t;

   function automatic logic [OCC_W-1:0] occ_of(input state_t s);
      case (s)
         EMPTY:   return 2'd0;
         ONE:     return 2'd1;
         FULL:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register with valid/ready on both sides.
// Ports: clk, rst (sync active-low), in_valid/in_ready/in_data,
// out_valid/out_ready/out_data, flush, occupancy (0..2).
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [OCC_W-1:0] occupancy
);

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] main_n;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_n;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [OCC_W-1:0] occ_q;
   logic             accept;
   logic             consume;

   // Handshake flags are registered from the next state so that no
   // combinational path exists from out_ready to in_ready.
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign occupancy = occ_q;

   always_comb begin
      accept  = in_valid & in_ready_q;
      consume = out_valid_q & out_ready;
      state_n = state;
      main_n  = main_q;
      skid_n  = skid_q;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_n = ONE;
               main_n  = in_data;
            end
         end
         ONE: begin
            if (accept && !consume) begin
               state_n = FULL;
               skid_n  = in_data;
            end else if (accept && consume) begin
               main_n  = in_data;
            end else if (consume) begin
               state_n = EMPTY;
            end
         end
         FULL: begin
            if (consume) begin
               state_n = ONE;
               main_n  = skid_q;
            end
         end
         default: state_n = EMPTY;
      endcase
      // Squash wins over any handshake in the same cycle.
      if (flush) begin
         state_n = EMPTY;
         main_n  = RESET_VALUE;
         skid_n  = RESET_VALUE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= EMPTY;
         main_q      <= RESET_VALUE;
         skid_q      <= RESET_VALUE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         occ_q       <= '0;
      end else begin
         state       <= state_n;
         main_q      <= main_n;
         skid_q      <= skid_n;
         in_ready_q  <= (state_n != FULL);
         out_valid_q <= (state_n != EMPTY);
         occ_q       <= occ_of(state_n);
      end
   end

endmodule
